// File: rtl/uart_seq_monitor.sv
// uart_seq_monitor: 8N1 UART receiver with an ascending-byte sequence checker.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   rx           async serial input, idle high
//   byte_valid   1-clk pulse when byte_out holds a frame with a good stop bit
//   byte_out     last received byte, stable until the next byte_valid
//   frame_err    1-clk pulse when the stop bit was sampled low
//   seq_ok       1-clk pulse when a byte matched the expected value
//   seq_err      1-clk pulse when a byte mismatched while locked
//   err_count    saturating count of seq_err pulses
//   locked       expected value is valid
//   stall        timeout expired and no byte has arrived since
//   led          toggles on every seq_ok
module uart_seq_monitor #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 24_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    output logic        frame_err,
    output logic        seq_ok,
    output logic        seq_err,
    output logic [15:0] err_count,
    output logic        locked,
    output logic        stall,
    output logic        led
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    expected;
    logic [TW-1:0] to_cnt;

    // Synchronizer flops reset to the idle level so that leaving reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // Mid-bit check rejects glitches shorter than half a bit.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            byte_out   <= shreg;
                            byte_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HI;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            expected  <= '0;
            err_count <= '0;
            locked    <= 1'b0;
            stall     <= 1'b0;
            led       <= 1'b0;
            seq_ok    <= 1'b0;
            seq_err   <= 1'b0;
            to_cnt    <= '0;
        end else begin
            seq_ok  <= 1'b0;
            seq_err <= 1'b0;
            if (byte_valid) begin
                // A byte arriving on the expiry clock wins: it is checked
                // under the current lock and the timeout is simply restarted.
                to_cnt   <= '0;
                stall    <= 1'b0;
                expected <= byte_out + 8'd1;
                if (!locked) begin
                    locked <= 1'b1;
                end else if (byte_out == expected) begin
                    seq_ok <= 1'b1;
                    led    <= ~led;
                end else begin
                    seq_err <= 1'b1;
                    if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
                end
            end else if (to_cnt == TO_LAST) begin
                locked <= 1'b0;
                stall  <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule
